// File: rtl/periph_pkg.sv
// Shared peripheral definitions: bus addresses, UART TX FSM states and UART_CON bit positions.
package periph_pkg;

    localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
    localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_e;

    // UART_CON register bit positions (TX half)
    localparam int CON_IRQ_EN_BIT    = 1;
    localparam int CON_TX_DONE_BIT   = 2;
    localparam int CON_HOLD_FULL_BIT = 3;
    localparam int CON_TX_BUSY_BIT   = 4;

    // Positions inside the 3-bit con_tx readback bundle
    localparam int CONTX_DONE = 0;
    localparam int CONTX_HOLD = 1;
    localparam int CONTX_BUSY = 2;

    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_periph_if.sv
// Peripheral bus port of the UART transmitter: CPU strobes in, UART_CON TX bits and irq out.
interface uart_tx_periph_if;
    logic        mem_wr;
    logic        mem_rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  con_tx;
    logic        irq_tx;

    modport master (output mem_wr, mem_rd, addr, wdata, input con_tx, irq_tx);
    modport slave  (input mem_wr, mem_rd, addr, wdata, output con_tx, irq_tx);
endinterface

// File: rtl/uart_tx_periph_baud.sv
// Bit-period counter: counts 0..DIV-1 while enabled and pulses bit_end on the last clock.
module baud_tick_gen #(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic bit_end
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign bit_end = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (en)
            cnt <= bit_end ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with one holding register behind the shifter.
module uart_tx_periph
    import periph_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_periph_if.slave  bus,
    output logic             txd
);
    localparam int DIV = baud_div(CLK_FREQ, BAUD);

    uart_tx_state_e state;
    logic [7:0] shifter, hold;
    logic [2:0] idx;
    logic       hold_full, tx_busy, tx_done, irq_en;
    logic       bit_end, consume, done_set;
    logic       wr_txd, wr_con, rd_con;
    logic       unused_wdata;

    assign wr_txd = bus.mem_wr && (bus.addr == UART_TXD_ADDR);
    assign wr_con = bus.mem_wr && (bus.addr == UART_CON_ADDR);
    assign rd_con = bus.mem_rd && (bus.addr == UART_CON_ADDR);
    assign unused_wdata = ^bus.wdata[31:8];

    // Hold is emptied either from IDLE or at the end of a stop bit (back-to-back reload)
    assign consume  = hold_full && ((state == IDLE) || ((state == STOP) && bit_end));
    assign done_set = (state == STOP) && bit_end;

    baud_tick_gen #(.DIV(DIV)) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clr     (consume),
        .en      (state != IDLE),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            txd       <= 1'b1;
            shifter   <= '0;
            hold      <= '0;
            idx       <= '0;
            hold_full <= 1'b0;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            irq_en    <= 1'b0;
        end else begin
            // A write landing on the consume cycle refills the freed hold register
            if (wr_txd && (!hold_full || consume)) begin
                hold      <= bus.wdata[7:0];
                hold_full <= 1'b1;
            end else if (consume) begin
                hold_full <= 1'b0;
            end

            if (wr_con)
                irq_en <= bus.wdata[CON_IRQ_EN_BIT];

            // Set wins over read-clear or explicit clear
            tx_done <= done_set
                     | (tx_done & ~(wr_con & bus.wdata[CON_TX_DONE_BIT]) & ~rd_con);

            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (hold_full) begin
                        shifter <= hold;
                        tx_busy <= 1'b1;
                        txd     <= 1'b0;
                        state   <= START;
                    end
                end
                START: if (bit_end) begin
                    idx   <= '0;
                    txd   <= shifter[0];
                    state <= DATA;
                end
                DATA: if (bit_end) begin
                    if (idx == 3'd7) begin
                        txd   <= 1'b1;
                        state <= STOP;
                    end else begin
                        idx <= idx + 3'd1;
                        txd <= shifter[idx + 3'd1];
                    end
                end
                STOP: if (bit_end) begin
                    if (hold_full) begin
                        shifter <= hold;
                        txd     <= 1'b0;
                        state   <= START;
                    end else begin
                        tx_busy <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.con_tx = {tx_busy, hold_full, tx_done};
    assign bus.irq_tx = tx_done & irq_en;

endmodule
